// File: rtl/fp_accum.sv
// Floating-point (fp24) batch accumulator: one operand every four cycles through
// ALIGN/ADD/NORM, sum presented in OUT until downstream accepts it.
module fp_accum #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [15:0] big_man_q, sml_man_q;
    logic [7:0]  exp_q;
    logic        sign_q, sub_q;
    logic [16:0] sum_q;

    logic        a_zero, b_zero, a_big;
    logic [22:0] a_mag, b_mag;
    logic [15:0] a_man, b_man, big_man, sml_man, sml_shift;
    logic [7:0]  big_exp, sml_exp, exp_diff;
    logic        big_sign, sml_sign;

    function automatic logic [4:0] clz16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) n = 5'(15 - i);
        end
        return n;
    endfunction

    // Normalise a 17-bit magnitude, then flush underflow to +0 and clamp overflow.
    function automatic logic [23:0] normalize(input logic [16:0] sum,
                                              input logic [7:0]  exp_in,
                                              input logic        sign);
        logic [4:0]        lz;
        logic [15:0]       man;
        logic signed [9:0] exp_n;
        lz = clz16(sum[15:0]);
        if (sum == 17'd0) return 24'h000000;
        if (sum[16]) begin
            man   = sum[16:1];
            exp_n = signed'({2'b00, exp_in}) + 10'sd1;
        end else begin
            man   = sum[15:0] << lz;
            exp_n = signed'({2'b00, exp_in}) - signed'({5'b00000, lz});
        end
        if (exp_n < 10'sd1) return 24'h000000;
        if (exp_n > 10'sd254) return {sign, 8'hFE, 15'h7FFF};
        return {sign, exp_n[7:0], man[14:0]};
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = acc_q;

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        last_d  = last_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (in_valid) begin
                opnd_d  = in_data;
                last_d  = in_last;
                state_d = ALIGN;
            end
            ALIGN: state_d = ADD;
            ADD:   state_d = NORM;
            NORM: begin
                acc_d   = normalize(sum_q, exp_q, sign_q);
                state_d = last_q ? OUT : IDLE;
            end
            OUT: if (out_ready) begin
                acc_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand selection: exponent-0 values are zero, larger magnitude stays unshifted.
    always_comb begin
        a_zero    = (acc_q[22:15] == 8'd0);
        b_zero    = (opnd_q[22:15] == 8'd0);
        a_mag     = a_zero ? 23'd0 : acc_q[22:0];
        b_mag     = b_zero ? 23'd0 : opnd_q[22:0];
        a_man     = a_zero ? 16'd0 : {1'b1, acc_q[14:0]};
        b_man     = b_zero ? 16'd0 : {1'b1, opnd_q[14:0]};
        a_big     = (a_mag >= b_mag);
        big_man   = a_big ? a_man : b_man;
        sml_man   = a_big ? b_man : a_man;
        big_exp   = a_big ? a_mag[22:15] : b_mag[22:15];
        sml_exp   = a_big ? b_mag[22:15] : a_mag[22:15];
        big_sign  = a_big ? acc_q[23] : opnd_q[23];
        sml_sign  = a_big ? opnd_q[23] : acc_q[23];
        exp_diff  = big_exp - sml_exp;
        sml_shift = (exp_diff >= 8'd17) ? 16'd0 : (sml_man >> exp_diff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
        end
    end

    // ALIGN -> ADD boundary
    always_ff @(posedge clk) begin
        if (state_q == ALIGN) begin
            big_man_q <= big_man;
            sml_man_q <= sml_shift;
            exp_q     <= big_exp;
            sign_q    <= big_sign;
            sub_q     <= big_sign ^ sml_sign;
        end
    end

    // ADD -> NORM boundary
    always_ff @(posedge clk) begin
        if (state_q == ADD) begin
            sum_q <= sub_q ? ({1'b0, big_man_q} - {1'b0, sml_man_q})
                           : ({1'b0, big_man_q} + {1'b0, sml_man_q});
        end
    end

endmodule

// File: tb/tb_fp_accum.sv
// Self-checking bench for fp_accum: directed corner cases plus random batches
// compared against an integer-arithmetic reference model.
module tb_fp_accum;

    typedef logic [23:0] op_arr_t [8];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = 24'h0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [23:0] out_data;
    logic        out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    fp_accum #(.WIDTH(24)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Reference: values as integer mantissa * 2^exp, truncating alignment and normalisation.
    function automatic logic [23:0] ref_add(input logic [23:0] a, input logic [23:0] b);
        int ea, eb, e, ma, mb, s, mag;
        logic neg;
        ea = int'(a[22:15]);
        eb = int'(b[22:15]);
        ma = (ea == 0) ? 0 : 32768 + int'(a[14:0]);
        mb = (eb == 0) ? 0 : 32768 + int'(b[14:0]);
        e  = (ea > eb) ? ea : eb;
        ma = (e - ea >= 17) ? 0 : ma / (1 << (e - ea));
        mb = (e - eb >= 17) ? 0 : mb / (1 << (e - eb));
        s  = (a[23] ? -ma : ma) + (b[23] ? -mb : mb);
        if (s == 0) return 24'h000000;
        neg = (s < 0);
        mag = neg ? -s : s;
        while (mag >= 65536) begin mag = mag / 2; e = e + 1; end
        while (mag < 32768) begin mag = mag * 2; e = e - 1; end
        if (e < 1) return 24'h000000;
        if (e > 254) return {neg, 8'hFE, 15'h7FFF};
        return {neg, 8'(e), 15'(mag - 32768)};
    endfunction

    function automatic logic [23:0] ref_batch(input op_arr_t ops, input int n);
        logic [23:0] acc;
        acc = 24'h0;
        for (int k = 0; k < n; k++) acc = ref_add(acc, ops[k]);
        return acc;
    endfunction

    function automatic logic [23:0] rand_op();
        int sel;
        logic [7:0] e;
        sel = $urandom_range(0, 9);
        if (sel == 0)      e = 8'd0;
        else if (sel <= 2) e = 8'($urandom_range(1, 254));
        else if (sel == 3) e = 8'($urandom_range(248, 254));
        else               e = 8'($urandom_range(118, 136));
        return {1'($urandom_range(0, 1)), e, 15'($urandom)};
    endfunction

    task automatic send_op(input logic [23:0] d, input logic last, output int gap);
        gap = 0;
        @(negedge clk);
        while (!in_ready && gap < 50) begin
            gap++;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_batch(input op_arr_t ops, input int n, input int hold,
                            output logic [23:0] res, output int lat, output int gap);
        for (int k = 0; k < n; k++) send_op(ops[k], (k == n - 1), gap);
        wait_out(lat);
        repeat (hold) @(negedge clk);
        res = out_data;
        release_out();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 24'h0) begin
            failures++;
            $display("FAIL reset_during ready=%b valid=%b data=%h want 1 0 000000", in_ready, out_valid, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 24'h0) begin
            failures++;
            $display("FAIL reset_after ready=%b valid=%b data=%h want 1 0 000000", in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_single();
        op_arr_t ops;
        logic [23:0] res;
        int lat, gap;
        ops[0] = 24'h3F8000;
        do_batch(ops, 1, 0, res, lat, gap);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL single_latency got %0d want 4", lat);
        end
        checks++;
        if (res !== 24'h3F8000) begin
            failures++;
            $display("FAIL single_value got %h want 3f8000", res);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 24'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_release valid=%b data=%h ready=%b want 0 000000 1", out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_two();
        op_arr_t ops;
        logic [23:0] res;
        int lat, gap;
        ops[0] = 24'h3F8000;
        ops[1] = 24'h400000;
        do_batch(ops, 2, 0, res, lat, gap);
        checks++;
        if (gap !== 3) begin
            failures++;
            $display("FAIL two_gap got %0d want 3", gap);
        end
        checks++;
        if (res !== 24'h404000) begin
            failures++;
            $display("FAIL two_value got %h want 404000", res);
        end
    endtask

    task automatic test_align();
        op_arr_t ops;
        logic [23:0] res, exp_v;
        logic [23:0] second [4];
        int lat, gap;
        second[0] = 24'hBF8000;
        second[1] = 24'h378000;
        second[2] = 24'h2F8000;
        second[3] = 24'h3B8000;
        for (int t = 0; t < 4; t++) begin
            ops[0] = 24'h3F8000;
            ops[1] = second[t];
            exp_v  = ref_batch(ops, 2);
            do_batch(ops, 2, 0, res, lat, gap);
            checks++;
            if (res !== exp_v) begin
                failures++;
                $display("FAIL align_%0d got %h want %h", t, res, exp_v);
            end
        end
        ops[0] = 24'h3F8000;
        ops[1] = 24'hBF8000;
        do_batch(ops, 2, 0, res, lat, gap);
        checks++;
        if (res !== 24'h000000) begin
            failures++;
            $display("FAIL cancel_zero got %h want 000000", res);
        end
        ops[0] = 24'h3F8000;
        ops[1] = 24'h3B8000;
        do_batch(ops, 2, 0, res, lat, gap);
        checks++;
        if (res !== 24'h3F8080) begin
            failures++;
            $display("FAIL one_plus_2m8 got %h want 3f8080", res);
        end
    endtask

    task automatic test_limits();
        op_arr_t ops;
        logic [23:0] res;
        int lat, gap;
        ops[0] = 24'h7F7FFF;
        ops[1] = 24'h7F7FFF;
        do_batch(ops, 2, 0, res, lat, gap);
        checks++;
        if (res !== 24'h7F7FFF) begin
            failures++;
            $display("FAIL saturate got %h want 7f7fff", res);
        end
        ops[0] = 24'hFF7FFF;
        ops[1] = 24'hFF7FFF;
        do_batch(ops, 2, 0, res, lat, gap);
        checks++;
        if (res !== 24'hFF7FFF) begin
            failures++;
            $display("FAIL saturate_neg got %h want ff7fff", res);
        end
        ops[0] = 24'h008000;
        ops[1] = 24'h808001;
        do_batch(ops, 2, 0, res, lat, gap);
        checks++;
        if (res !== 24'h000000) begin
            failures++;
            $display("FAIL underflow got %h want 000000", res);
        end
        ops[0] = 24'h807FFF;
        do_batch(ops, 1, 0, res, lat, gap);
        checks++;
        if (res !== 24'h000000) begin
            failures++;
            $display("FAIL exp0_operand got %h want 000000", res);
        end
    endtask

    task automatic test_back_pressure();
        op_arr_t ops;
        logic [23:0] res;
        int lat, gap;
        send_op(24'h404000, 1'b1, gap);
        wait_out(lat);
        in_valid = 1'b1;
        in_data  = 24'h3F8000;
        in_last  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 24'h404000 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d valid=%b data=%h ready=%b want 1 404000 0", c, out_valid, out_data, in_ready);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        release_out();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 24'h0) begin
            failures++;
            $display("FAIL hold_release valid=%b data=%h want 0 000000", out_valid, out_data);
        end
        ops[0] = 24'h3F8000;
        do_batch(ops, 1, 0, res, lat, gap);
        checks++;
        if (res !== 24'h3F8000) begin
            failures++;
            $display("FAIL after_hold got %h want 3f8000", res);
        end
    endtask

    task automatic test_reset_mid();
        op_arr_t ops;
        logic [23:0] res;
        int lat, gap, seen;
        send_op(24'h3F8000, 1'b0, gap);
        send_op(24'h400000, 1'b0, gap);
        send_op(24'h404000, 1'b1, gap);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 24'h0) begin
            failures++;
            $display("FAIL rst_in_add ready=%b valid=%b data=%h want 1 0 000000", in_ready, out_valid, out_data);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_discard out_valid cycles=%0d want 0", seen);
        end
        ops[0] = 24'h3F8000;
        do_batch(ops, 1, 0, res, lat, gap);
        checks++;
        if (res !== 24'h3F8000) begin
            failures++;
            $display("FAIL rst_new_batch got %h want 3f8000", res);
        end
        send_op(24'h400000, 1'b1, gap);
        wait_out(lat);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 24'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_out valid=%b data=%h ready=%b want 0 000000 1", out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_random();
        op_arr_t ops;
        logic [23:0] res, exp_v;
        int lat, gap, n, hold;
        for (int b = 0; b < 60; b++) begin
            n    = $urandom_range(1, 6);
            hold = $urandom_range(0, 3);
            for (int k = 0; k < 8; k++) ops[k] = rand_op();
            exp_v = ref_batch(ops, n);
            do_batch(ops, n, hold, res, lat, gap);
            checks++;
            if (lat !== 4 || res !== exp_v) begin
                failures++;
                $display("FAIL random_batch%0d n=%0d lat=%0d got %h want lat 4 data %h", b, n, lat, res, exp_v);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_two();
        test_align();
        test_limits();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
